lsu_dccm_mem: RTL and testbench
===============================

LSU_DCCM_MEM -- requirements
Module: lsu_dccm_mem

Interface
REQ-001 SHALL have these parameters:
- DCCM_BITS, default 12, byte-address width.
- DCCM_BANK_BITS, default 3, log2 of the bank count.
- DCCM_DATA_WIDTH, default 32, data bits per word.
- DCCM_ECC_WIDTH, default 7, ECC bits per word.
- DCCM_FDATA_WIDTH, default 39, stored word width (ECC in the upper bits, data in the lower bits).
REQ-002 SHALL have these ports (clock and reset first):
- clk  in  1  single clock.
- rst_l  in  1  reset, asynchronous, active-low.
- dccm_wren  in  1  write strobe.
- dccm_rden  in  1  read strobe.
- dccm_wr_addr  in  DCCM_BITS  write byte address.
- dccm_rd_addr_lo  in  DCCM_BITS  read address, lo word.
- dccm_rd_addr_hi  in  DCCM_BITS  read address, hi word.
- dccm_wr_data  in  DCCM_FDATA_WIDTH  write word.
- dccm_rd_data_lo  out  DCCM_FDATA_WIDTH  lo read word.
- dccm_rd_data_hi  out  DCCM_FDATA_WIDTH  hi read word.
- dccm_init_done  out  1  array clear complete.
- dccm_bank_conflict  out  1  same-bank read/write collision seen last cycle.
- scan_mode  in  1  scan; no functional effect.
REQ-003 SHALL use exactly one clock, clk; reset SHALL be asynchronous and active-low on rst_l.

Function
REQ-004 Address decode SHALL be: bank = addr[2 +: DCCM_BANK_BITS], row = addr[DCCM_BITS-1 : 2+DCCM_BANK_BITS], addr[1:0] ignored.
REQ-005 Array size SHALL be 2^DCCM_BANK_BITS banks x ROWS words, ROWS = 2^(DCCM_BITS-DCCM_BANK_BITS-2); the default gives 8 banks x 128 rows.
REQ-006 Read latency SHALL be 1 cycle: rden high at edge N updates both rd_data outputs at edge N with the array contents before any write of edge N.
REQ-007 The lo and hi read ports SHALL be independent; if both decode to the same bank and row, both outputs SHALL show the same word.
REQ-008 If rden is low, both rd_data outputs SHALL hold their previous values.
REQ-009 A write with wren high at edge N SHALL update bank/row of wr_addr at edge N with the full FDATA word; no partial writes.
REQ-010 On a same-edge read and write to the same bank (either read port): the read SHALL return the old data, the write SHALL complete, and dccm_bank_conflict SHALL be 1 for the following cycle.
REQ-011 dccm_bank_conflict SHALL be 0 in every other case, including a write and read to different banks on the same edge.
REQ-012 Init FSM SHALL have two states:
- INIT: row counter row_cnt clears row row_cnt in all banks to all-zero FDATA each cycle.
- READY: normal operation.
REQ-013 INIT->READY SHALL occur on the edge that clears row ROWS-1; READY SHALL have no exit except reset.
REQ-014 dccm_init_done SHALL be 0 in INIT and 1 in READY; it first reads 1 exactly ROWS cycles after rst_l deasserts.
REQ-015 In INIT, wren and rden SHALL be ignored: no array update, rd_data held, and dccm_bank_conflict held at 0.
REQ-016 All-zero FDATA SHALL be treated as valid-ECC zero data, so reads of cleared rows return 0.
REQ-017 row_cnt SHALL be ROW_BITS wide, saturate at ROWS-1, and never wrap.

Reset
REQ-018 While rst_l is low:
- FSM = INIT, row_cnt = 0.
- dccm_rd_data_lo = dccm_rd_data_hi = 0.
- dccm_init_done = 0, dccm_bank_conflict = 0.
REQ-019 Array contents SHALL NOT be reset directly; they are cleared only by the INIT sequence.
REQ-020 Reset asserted mid-INIT or in READY SHALL abort immediately and restart the clear from row 0 after rst_l deasserts.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Init: release rst_l -> init_done=0 for 128 cycles, then 1; read of addr 0x0FC returns 0; wren during INIT to 0x010 (data 0x5A) is not visible after READY.
- Write then read: write 0x040 = 0x12_3456789A; next cycle rden with lo=hi=0x040 -> both outputs 0x12_3456789A one cycle later.
- Dual bank: write 0x044 = A, 0x048 = B; read lo=0x044, hi=0x048 -> lo=A, hi=B; outputs hold after rden drops.
- Conflict: 0x080 holds C; same edge write 0x080 = D and read lo=0x080 -> rd_data_lo=C, bank_conflict=1 for one cycle; next read returns D.
- No conflict: same edge write 0x084, read 0x088 -> bank_conflict=0, read correct.
- Reset mid-op: assert rst_l low at INIT row 50 -> outputs 0; after release, init_done rises only after a full 128 cycles.

Source files
------------

// File: rtl/lsu_dccm_mem.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dccm_mem
// Description : Banked DCCM array with two independent read ports, one write
//               port, a power-on clear sequence and same-bank collision flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dccm_mem #(
    parameter int DCCM_BITS        = 12,
    parameter int DCCM_BANK_BITS   = 3,
    parameter int DCCM_DATA_WIDTH  = 32,
    parameter int DCCM_ECC_WIDTH   = 7,
    parameter int DCCM_FDATA_WIDTH = 39
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        dccm_wren,
    input  logic                        dccm_rden,
    input  logic [DCCM_BITS-1:0]        dccm_wr_addr,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    input  logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi,
    output logic                        dccm_init_done,
    output logic                        dccm_bank_conflict,
    input  logic                        scan_mode
);

    localparam int c_ROW_BITS = DCCM_BITS - DCCM_BANK_BITS - 2;
    localparam int c_ROWS     = 1 << c_ROW_BITS;
    localparam int c_BANKS    = 1 << DCCM_BANK_BITS;
    localparam logic [c_ROW_BITS-1:0] c_LAST_ROW = c_ROW_BITS'(c_ROWS - 1);
    // All-zero ECC over all-zero data is a valid codeword, so cleared rows read as clean zero.
    localparam logic [DCCM_FDATA_WIDTH-1:0] c_CLEAR_WORD =
        {{DCCM_ECC_WIDTH{1'b0}}, {DCCM_DATA_WIDTH{1'b0}}};

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic                        w_init_active;
    logic [c_ROW_BITS-1:0]       r_row_cnt;
    logic [DCCM_FDATA_WIDTH-1:0] r_rd_data_lo;
    logic [DCCM_FDATA_WIDTH-1:0] r_rd_data_hi;
    logic                        r_bank_conflict;
    logic                        w_conflict;

    logic [DCCM_BANK_BITS-1:0]   w_wr_bank;
    logic [DCCM_BANK_BITS-1:0]   w_lo_bank;
    logic [DCCM_BANK_BITS-1:0]   w_hi_bank;
    logic [c_ROW_BITS-1:0]       w_wr_row;
    logic [c_ROW_BITS-1:0]       w_lo_row;
    logic [c_ROW_BITS-1:0]       w_hi_row;
    logic [DCCM_FDATA_WIDTH-1:0] w_bank_rd_lo [c_BANKS];
    logic [DCCM_FDATA_WIDTH-1:0] w_bank_rd_hi [c_BANKS];
    logic                        w_unused;

    // Byte offset bits and scan_mode carry no function in this array.
    assign w_unused = &{1'b0, scan_mode, dccm_wr_addr[1:0],
                        dccm_rd_addr_lo[1:0], dccm_rd_addr_hi[1:0]};

    assign w_wr_bank = dccm_wr_addr[2 +: DCCM_BANK_BITS];
    assign w_lo_bank = dccm_rd_addr_lo[2 +: DCCM_BANK_BITS];
    assign w_hi_bank = dccm_rd_addr_hi[2 +: DCCM_BANK_BITS];
    assign w_wr_row  = dccm_wr_addr[DCCM_BITS-1 : 2+DCCM_BANK_BITS];
    assign w_lo_row  = dccm_rd_addr_lo[DCCM_BITS-1 : 2+DCCM_BANK_BITS];
    assign w_hi_row  = dccm_rd_addr_hi[DCCM_BITS-1 : 2+DCCM_BANK_BITS];

    // Init FSM state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= c_ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // Leave INIT on the edge that clears the last row; READY only exits through reset.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_ST_INIT && r_row_cnt == c_LAST_ROW) w_state_nxt = c_ST_READY;
    end

    // FSM outputs.
    always_comb begin
        w_init_active  = (r_state == c_ST_INIT);
        dccm_init_done = (r_state == c_ST_READY);
    end

    // Clear-row counter: advances through INIT and parks on the last row.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                                       r_row_cnt <= '0;
        else if (w_init_active && r_row_cnt != c_LAST_ROW) r_row_cnt <= r_row_cnt + 1'b1;
    end

    for (genvar b = 0; b < c_BANKS; b++) begin : g_bank
        logic [DCCM_FDATA_WIDTH-1:0] r_mem [c_ROWS];
        logic                        w_we;
        logic [c_ROW_BITS-1:0]       w_waddr;
        logic [DCCM_FDATA_WIDTH-1:0] w_wdata;

        // During INIT every bank clears the counter row; afterwards only the addressed bank writes.
        always_comb begin
            w_we    = 1'b0;
            w_waddr = w_wr_row;
            w_wdata = dccm_wr_data;
            if (w_init_active) begin
                w_we    = 1'b1;
                w_waddr = r_row_cnt;
                w_wdata = c_CLEAR_WORD;
            end else if (dccm_wren && w_wr_bank == DCCM_BANK_BITS'(b)) begin
                w_we = 1'b1;
            end
        end

        // Storage has no reset; contents are only cleared by the INIT sweep.
        always_ff @(posedge clk) begin
            if (w_we) r_mem[w_waddr] <= w_wdata;
        end

        assign w_bank_rd_lo[b] = r_mem[w_lo_row];
        assign w_bank_rd_hi[b] = r_mem[w_hi_row];
    end

    // Read registers capture pre-write array contents and hold when not reading.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rd_data_lo <= '0;
            r_rd_data_hi <= '0;
        end else if (!w_init_active && dccm_rden) begin
            r_rd_data_lo <= w_bank_rd_lo[w_lo_bank];
            r_rd_data_hi <= w_bank_rd_hi[w_hi_bank];
        end
    end

    assign w_conflict = !w_init_active && dccm_wren && dccm_rden &&
                        ((w_wr_bank == w_lo_bank) || (w_wr_bank == w_hi_bank));

    // Collision flag reports the previous edge only.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_bank_conflict <= 1'b0;
        else        r_bank_conflict <= w_conflict;
    end

    assign dccm_rd_data_lo    = r_rd_data_lo;
    assign dccm_rd_data_hi    = r_rd_data_hi;
    assign dccm_bank_conflict = r_bank_conflict;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dccm_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_dccm_mem
// Description : Self-checking bench for lsu_dccm_mem against a flat word-array
//               reference model, directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dccm_mem;

    localparam int ROWS  = 128;
    localparam int WORDS = 1024;
    localparam int BANKS = 8;
    localparam int FW    = 39;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          dccm_wren;
    logic          dccm_rden;
    logic [11:0]   dccm_wr_addr;
    logic [11:0]   dccm_rd_addr_lo;
    logic [11:0]   dccm_rd_addr_hi;
    logic [FW-1:0] dccm_wr_data;
    logic [FW-1:0] dccm_rd_data_lo;
    logic [FW-1:0] dccm_rd_data_hi;
    logic          dccm_init_done;
    logic          dccm_bank_conflict;
    logic          scan_mode;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: flat word memory indexed by byte address / 4.
    logic [FW-1:0] m_mem [WORDS];
    logic [FW-1:0] m_lo;
    logic [FW-1:0] m_hi;
    logic          m_conf;
    logic          m_done;
    int            m_cnt;

    always #5 clk = ~clk;

    lsu_dccm_mem dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .dccm_wren          (dccm_wren),
        .dccm_rden          (dccm_rden),
        .dccm_wr_addr       (dccm_wr_addr),
        .dccm_rd_addr_lo    (dccm_rd_addr_lo),
        .dccm_rd_addr_hi    (dccm_rd_addr_hi),
        .dccm_wr_data       (dccm_wr_data),
        .dccm_rd_data_lo    (dccm_rd_data_lo),
        .dccm_rd_data_hi    (dccm_rd_data_hi),
        .dccm_init_done     (dccm_init_done),
        .dccm_bank_conflict (dccm_bank_conflict),
        .scan_mode          (scan_mode)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [11:0] a);
        return int'(a) / 4;
    endfunction

    function automatic int bank_of(input logic [11:0] a);
        return word_of(a) % BANKS;
    endfunction

    // Behaviour of one rising edge given the inputs currently applied.
    task automatic model_edge();
        if (!rst_l) begin
            m_cnt  = 0;
            m_lo   = '0;
            m_hi   = '0;
            m_conf = 1'b0;
        end else if (m_cnt < ROWS) begin
            for (int w = 0; w < WORDS; w++)
                if (w / BANKS == m_cnt) m_mem[w] = '0;
            m_cnt++;
            m_conf = 1'b0;
        end else begin
            m_conf = dccm_wren && dccm_rden &&
                     (bank_of(dccm_wr_addr) == bank_of(dccm_rd_addr_lo) ||
                      bank_of(dccm_wr_addr) == bank_of(dccm_rd_addr_hi));
            if (dccm_rden) begin
                m_lo = m_mem[word_of(dccm_rd_addr_lo)];
                m_hi = m_mem[word_of(dccm_rd_addr_hi)];
            end
            if (dccm_wren) m_mem[word_of(dccm_wr_addr)] = dccm_wr_data;
        end
        m_done = (m_cnt >= ROWS);
    endtask

    task automatic compare_all();
        check("rd_lo",     64'(dccm_rd_data_lo),    64'(m_lo));
        check("rd_hi",     64'(dccm_rd_data_hi),    64'(m_hi));
        check("conflict",  64'(dccm_bank_conflict), 64'(m_conf));
        check("init_done", 64'(dccm_init_done),     64'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic w, input logic r, input logic [11:0] wa,
                         input logic [11:0] lo, input logic [11:0] hi, input logic [FW-1:0] d);
        dccm_wren       = w;
        dccm_rden       = r;
        dccm_wr_addr    = wa;
        dccm_rd_addr_lo = lo;
        dccm_rd_addr_hi = hi;
        dccm_wr_data    = d;
    endtask

    task automatic assert_reset();
        rst_l = 1'b0;
        #1;
        m_cnt  = 0;
        m_lo   = '0;
        m_hi   = '0;
        m_conf = 1'b0;
        m_done = 1'b0;
        compare_all();
    endtask

    task automatic drive_random(input logic narrow);
        logic [63:0] t;
        logic [11:0] wa, lo, hi;
        t  = {$urandom(), $urandom()};
        wa = 12'($urandom_range(0, 4095));
        lo = 12'($urandom_range(0, 4095));
        hi = 12'($urandom_range(0, 4095));
        if (narrow) begin
            wa = wa & 12'h0FF;
            lo = lo & 12'h0FF;
            hi = hi & 12'h0FF;
        end
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa, lo, hi, t[FW-1:0]);
    endtask

    initial begin
        logic [FW-1:0] a, b, c, d;
        a = 39'h12_3456789A;
        b = 39'h41_0000AAAA;
        c = 39'h0C_CCCC0001;
        d = 39'h5D_DDDD0002;
        for (int w = 0; w < WORDS; w++) m_mem[w] = '0;
        m_lo = '0; m_hi = '0; m_conf = 1'b0; m_done = 1'b0; m_cnt = 0;
        scan_mode = 1'b0;
        rst_l     = 1'b0;
        drive(0, 0, 12'h000, 12'h000, 12'h000, '0);

        repeat (3) tick();

        // First init, aborted by reset at row 50.
        rst_l = 1'b1;
        repeat (50) tick();
        check("mid_init_not_done", 64'(dccm_init_done), 64'd0);
        assert_reset();
        repeat (2) tick();

        // Full init with writes/reads attempted mid-sweep.
        rst_l = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            if (i >= 100 && i < 110) drive(1, 1, 12'h010, 12'h010, 12'h0FC, 39'h5A);
            else                     drive(0, 0, 12'h000, 12'h000, 12'h000, '0);
            tick();
        end
        check("init_done_after_128", 64'(dccm_init_done), 64'd1);

        drive(0, 1, 12'h000, 12'h0FC, 12'h010, '0);
        tick();
        check("cleared_0x0FC", 64'(dccm_rd_data_lo), 64'd0);
        check("init_write_ignored_0x010", 64'(dccm_rd_data_hi), 64'd0);

        // Write then read on both ports.
        drive(1, 0, 12'h040, 12'h000, 12'h000, a);
        tick();
        drive(0, 1, 12'h000, 12'h040, 12'h040, '0);
        tick();
        check("wr_rd_lo", 64'(dccm_rd_data_lo), 64'(a));
        check("wr_rd_hi", 64'(dccm_rd_data_hi), 64'(a));

        // Two banks, then hold after rden drops.
        drive(1, 0, 12'h044, 12'h000, 12'h000, b);
        tick();
        drive(1, 0, 12'h048, 12'h000, 12'h000, a ^ b);
        tick();
        drive(0, 1, 12'h000, 12'h044, 12'h048, '0);
        tick();
        drive(0, 0, 12'h000, 12'h000, 12'h000, '0);
        repeat (2) tick();
        check("dual_hold_lo", 64'(dccm_rd_data_lo), 64'(b));
        check("dual_hold_hi", 64'(dccm_rd_data_hi), 64'(a ^ b));

        // Same-bank collision: old data returned, flag for one cycle, write lands.
        drive(1, 0, 12'h080, 12'h000, 12'h000, c);
        tick();
        drive(1, 1, 12'h080, 12'h080, 12'h0A4, d);
        tick();
        check("conflict_old_data", 64'(dccm_rd_data_lo), 64'(c));
        check("conflict_flag", 64'(dccm_bank_conflict), 64'd1);
        drive(0, 1, 12'h000, 12'h080, 12'h080, '0);
        tick();
        check("conflict_flag_clears", 64'(dccm_bank_conflict), 64'd0);
        check("conflict_new_data", 64'(dccm_rd_data_lo), 64'(d));

        // Different banks on the same edge: no collision.
        drive(1, 1, 12'h084, 12'h088, 12'h08C, c ^ d);
        tick();
        check("no_conflict_flag", 64'(dccm_bank_conflict), 64'd0);
        check("no_conflict_read", 64'(dccm_rd_data_lo), 64'd0);

        // Random traffic in READY.
        for (int i = 0; i < 600; i++) begin
            drive_random(1'(i % 2));
            tick();
        end

        // Reset from READY with live outputs.
        drive(0, 1, 12'h000, 12'h040, 12'h044, '0);
        tick();
        assert_reset();
        check("ready_reset_lo", 64'(dccm_rd_data_lo), 64'd0);
        drive(0, 0, 12'h000, 12'h000, 12'h000, '0);
        repeat (2) tick();
        rst_l = 1'b1;
        for (int i = 0; i < ROWS + 2; i++) begin
            drive_random(1'b0);
            tick();
        end
        drive(0, 1, 12'h000, 12'h040, 12'h080, '0);
        tick();
        check("reinit_cleared_lo", 64'(dccm_rd_data_lo), 64'd0);
        check("reinit_cleared_hi", 64'(dccm_rd_data_hi), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
